ula_serial_n_bits: RTL and testbench

Parametrised, multi-cycle successor to the 8-bit ULA. It computes the full 74181 function set (16 logic + 16 arithmetic) on WIDTH-bit operands. The operands pass through one ula_4_bits slice, one nibble per clock, LSB nibble first, with the carry held in a register between cycles. Operands enter through a valid/ready handshake and results leave through a second one, so the block sits between a register-file read stage and a writeback stage.

---
 rtl/ula_pkg.sv | 17 +
 rtl/ula_4_bits.sv | 76 +++++++
 rtl/ula_serial_n_bits.sv | 152 +++++++++++++++
 tb/tb_ula_serial_n_bits.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ula_pkg.sv
// Shared types and constants for the nibble-serial 74181-style ALU.
// Function codes follow the 74181 active-low-data table, applied to plain active-high values.
package ula_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } ula_state_t;

   localparam int SLICE_W = 4;

   localparam logic [3:0] S_ADD = 4'b1001;  // A PLUS B
   localparam logic [3:0] S_DEC = 4'b0000;  // A MINUS 1 (arithmetic mode)
   localparam logic [3:0] S_SUB = 4'b0110;  // A MINUS B MINUS 1

endpackage

// File: rtl/ula_4_bits.sv
// Combinational 4-bit 74181-style slice: 16 logic and 16 arithmetic functions.
// Carry in/out are active-high; a_eq_b reports plain nibble equality in every mode.
module ula_4_bits
   import ula_pkg::*;
(
   input  logic [SLICE_W-1:0] i_a,
   input  logic [SLICE_W-1:0] i_b,
   input  logic [3:0]         i_s,
   input  logic               i_m,
   input  logic               i_c_in,
   output logic [SLICE_W-1:0] o_f,
   output logic               o_a_eq_b,
   output logic               o_c_out
);

   logic [SLICE_W-1:0] w_x;
   logic [SLICE_W-1:0] w_y;
   logic [SLICE_W-1:0] w_logic;
   logic [SLICE_W:0]   w_sum;
   logic [SLICE_W-1:0] w_ones;

   assign w_ones = '1;

   // Arithmetic functions are X plus Y plus carry; "minus 1" is adding all ones.
   always_comb begin
      w_x = '0;
      w_y = '0;
      case (i_s)
         4'b0000: begin w_x = i_a;          w_y = w_ones;       end
         4'b0001: begin w_x = i_a & i_b;    w_y = w_ones;       end
         4'b0010: begin w_x = i_a & ~i_b;   w_y = w_ones;       end
         4'b0011: begin w_x = w_ones;       w_y = '0;           end
         4'b0100: begin w_x = i_a;          w_y = i_a | ~i_b;   end
         4'b0101: begin w_x = i_a & i_b;    w_y = i_a | ~i_b;   end
         4'b0110: begin w_x = i_a;          w_y = ~i_b;         end
         4'b0111: begin w_x = i_a | ~i_b;   w_y = '0;           end
         4'b1000: begin w_x = i_a;          w_y = i_a | i_b;    end
         4'b1001: begin w_x = i_a;          w_y = i_b;          end
         4'b1010: begin w_x = i_a & ~i_b;   w_y = i_a | i_b;    end
         4'b1011: begin w_x = i_a | i_b;    w_y = '0;           end
         4'b1100: begin w_x = i_a;          w_y = i_a;          end
         4'b1101: begin w_x = i_a & i_b;    w_y = i_a;          end
         4'b1110: begin w_x = i_a & ~i_b;   w_y = i_a;          end
         default: begin w_x = i_a;          w_y = '0;           end
      endcase
   end

   assign w_sum = {1'b0, w_x} + {1'b0, w_y} + {{SLICE_W{1'b0}}, i_c_in};

   always_comb begin
      w_logic = '0;
      case (i_s)
         4'b0000: w_logic = ~i_a;
         4'b0001: w_logic = ~(i_a & i_b);
         4'b0010: w_logic = ~i_a | i_b;
         4'b0011: w_logic = w_ones;
         4'b0100: w_logic = ~(i_a | i_b);
         4'b0101: w_logic = ~i_b;
         4'b0110: w_logic = ~(i_a ^ i_b);
         4'b0111: w_logic = i_a | ~i_b;
         4'b1000: w_logic = ~i_a & i_b;
         4'b1001: w_logic = i_a ^ i_b;
         4'b1010: w_logic = i_b;
         4'b1011: w_logic = i_a | i_b;
         4'b1100: w_logic = '0;
         4'b1101: w_logic = i_a & ~i_b;
         4'b1110: w_logic = i_a & i_b;
         default: w_logic = i_a;
      endcase
   end

   assign o_f      = i_m ? w_logic : w_sum[SLICE_W-1:0];
   assign o_c_out  = w_sum[SLICE_W];
   assign o_a_eq_b = (i_a == i_b);

endmodule

// File: rtl/ula_serial_n_bits.sv
// WIDTH-bit 74181-style ALU evaluated one nibble per clock through a single slice.
// Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
module ula_serial_n_bits
   import ula_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       s,
   input  logic             m,
   input  logic             c_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] f,
   output logic             a_eq_b,
   output logic             c_out,
   output logic             busy,
   output ula_state_t       dbg_state
);

   localparam int NSLICE = WIDTH / SLICE_W;
   localparam int CNT_W  = (NSLICE > 2) ? $clog2(NSLICE) : 1;
   localparam int IDX_W  = CNT_W + 2;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(NSLICE - 1);

   generate
      if ((WIDTH % SLICE_W) != 0 || WIDTH < 8) begin : g_bad_width
         $error("ula_serial_n_bits: WIDTH must be a multiple of 4 and at least 8");
      end
   endgenerate

   ula_state_t         r_state;
   ula_state_t         w_next_state;
   logic [CNT_W-1:0]   r_cnt;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic [3:0]         r_s;
   logic               r_m;
   logic               r_carry;
   logic               r_eq;
   logic [WIDTH-1:0]   r_f;
   logic               r_a_eq_b;
   logic               r_c_out;
   logic               r_out_valid;

   logic               w_accept;
   logic               w_release;
   logic               w_last;
   logic [IDX_W-1:0]   w_base;
   logic [SLICE_W-1:0] w_a_nib;
   logic [SLICE_W-1:0] w_b_nib;
   logic [SLICE_W-1:0] w_slice_f;
   logic               w_slice_eq;
   logic               w_slice_c;

   assign w_accept  = in_valid & in_ready;
   assign w_release = r_out_valid & out_ready;
   assign w_last    = (r_cnt == LAST);
   assign w_base    = {r_cnt, 2'b00};  // nibble index times SLICE_W
   assign w_a_nib   = r_a[w_base +: SLICE_W];
   assign w_b_nib   = r_b[w_base +: SLICE_W];

   ula_4_bits u_slice (
      .i_a      (w_a_nib),
      .i_b      (w_b_nib),
      .i_s      (r_s),
      .i_m      (r_m),
      .i_c_in   (r_carry),
      .o_f      (w_slice_f),
      .o_a_eq_b (w_slice_eq),
      .o_c_out  (w_slice_c)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (w_accept)  w_next_state = RUN;
         RUN:     if (w_last)    w_next_state = DONE;
         DONE:    if (w_release) w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   always_comb begin
      in_ready = 1'b0;
      busy     = 1'b0;
      case (r_state)
         IDLE:    in_ready = 1'b1;
         RUN:     busy     = 1'b1;
         DONE:    busy     = 1'b1;
         default: in_ready = 1'b0;
      endcase
   end

   // Result bits of nibbles not yet visited keep stale data until out_valid rises.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt       <= '0;
         r_a         <= '0;
         r_b         <= '0;
         r_s         <= '0;
         r_m         <= 1'b0;
         r_carry     <= 1'b0;
         r_eq        <= 1'b0;
         r_f         <= '0;
         r_a_eq_b    <= 1'b0;
         r_c_out     <= 1'b0;
         r_out_valid <= 1'b0;
      end else if (w_accept) begin
         r_a     <= a;
         r_b     <= b;
         r_s     <= s;
         r_m     <= m;
         r_carry <= c_in;
         r_cnt   <= '0;
         r_eq    <= 1'b1;
      end else if (r_state == RUN) begin
         r_f[w_base +: SLICE_W] <= w_slice_f;
         r_carry                <= w_slice_c;
         r_eq                   <= r_eq & w_slice_eq;
         if (w_last) begin
            r_c_out     <= w_slice_c;
            r_a_eq_b    <= r_eq & w_slice_eq;
            r_out_valid <= 1'b1;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end else if (w_release) begin
         r_out_valid <= 1'b0;
      end
   end

   assign out_valid = r_out_valid;
   assign f         = r_f;
   assign a_eq_b    = r_a_eq_b;
   assign c_out     = r_c_out;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_ula_serial_n_bits.sv
// Bench for ula_serial_n_bits: a 16-bit and a 32-bit instance checked against a
// full-width arithmetic reference of the 74181 function table.
module tb_ula_serial_n_bits;
   import ula_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;

   logic        in_valid_n, in_ready_n, m_n, cin_n, out_valid_n, out_ready_n, eq_n, c_n, busy_n;
   logic [15:0] a_n, b_n, f_n;
   logic [3:0]  s_n;
   ula_state_t  st_n;

   logic        in_valid_w, in_ready_w, m_w, cin_w, out_valid_w, out_ready_w, eq_w, c_w, busy_w;
   logic [31:0] a_w, b_w, f_w;
   logic [3:0]  s_w;
   ula_state_t  st_w;

   int n_tests = 0;
   int n_fail  = 0;
   logic [33:0] exp_q[$];  // {a_eq_b, c_out, f}

   ula_serial_n_bits #(.WIDTH(16)) u_dut_n (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_n), .in_ready(in_ready_n),
      .a(a_n), .b(b_n), .s(s_n), .m(m_n), .c_in(cin_n),
      .out_valid(out_valid_n), .out_ready(out_ready_n), .f(f_n),
      .a_eq_b(eq_n), .c_out(c_n), .busy(busy_n), .dbg_state(st_n)
   );

   ula_serial_n_bits #(.WIDTH(32)) u_dut_w (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_w), .in_ready(in_ready_w),
      .a(a_w), .b(b_w), .s(s_w), .m(m_w), .c_in(cin_w),
      .out_valid(out_valid_w), .out_ready(out_ready_w), .f(f_w),
      .a_eq_b(eq_w), .c_out(c_w), .busy(busy_w), .dbg_state(st_w)
   );

   // Reference: {carry, f} computed on whole operands of width w.
   function automatic logic [32:0] ref_alu(input logic [31:0] a_i, input logic [31:0] b_i,
                                           input logic [3:0] s_i, input logic m_i,
                                           input logic cin_i, input int w);
      longint unsigned mask, av, bv, nb, x, y, r;
      logic [63:0] rv;
      mask = (64'd1 << w) - 64'd1;
      av = {32'd0, a_i} & mask;
      bv = {32'd0, b_i} & mask;
      nb = ~bv & mask;
      x = 0;
      y = 0;
      if (m_i) begin
         case (s_i)
            4'd0:    r = ~av;
            4'd1:    r = ~(av & bv);
            4'd2:    r = ~av | bv;
            4'd3:    r = mask;
            4'd4:    r = ~(av | bv);
            4'd5:    r = nb;
            4'd6:    r = ~(av ^ bv);
            4'd7:    r = av | nb;
            4'd8:    r = ~av & bv;
            4'd9:    r = av ^ bv;
            4'd10:   r = bv;
            4'd11:   r = av | bv;
            4'd12:   r = 0;
            4'd13:   r = av & nb;
            4'd14:   r = av & bv;
            default: r = av;
         endcase
         rv = r & mask;
         return {1'b0, rv[31:0]};
      end
      case (s_i)
         4'd0:    begin x = av;      y = mask;    end
         4'd1:    begin x = av & bv; y = mask;    end
         4'd2:    begin x = av & nb; y = mask;    end
         4'd3:    begin x = mask;    y = 0;       end
         4'd4:    begin x = av;      y = av | nb; end
         4'd5:    begin x = av & bv; y = av | nb; end
         4'd6:    begin x = av;      y = nb;      end
         4'd7:    begin x = av | nb; y = 0;       end
         4'd8:    begin x = av;      y = av | bv; end
         4'd9:    begin x = av;      y = bv;      end
         4'd10:   begin x = av & nb; y = av | bv; end
         4'd11:   begin x = av | bv; y = 0;       end
         4'd12:   begin x = av;      y = av;      end
         4'd13:   begin x = av & bv; y = av;      end
         4'd14:   begin x = av & nb; y = av;      end
         default: begin x = av;      y = 0;       end
      endcase
      rv = x + y + {63'd0, cin_i};
      return {rv[w], rv[31:0] & mask[31:0]};
   endfunction

   // One operation with out_ready held high; lat counts edges from the accepting edge (=1).
   task automatic run_op(input bit wide, input logic [31:0] a_i, input logic [31:0] b_i,
                         input logic [3:0] s_i, input logic m_i, input logic cin_i,
                         output logic [31:0] f_o, output logic c_o, output logic eq_o,
                         output int lat);
      f_o = '0; c_o = 1'b0; eq_o = 1'b0; lat = 0;
      if (wide) begin
         a_w = a_i; b_w = b_i; s_w = s_i; m_w = m_i; cin_w = cin_i; in_valid_w = 1'b1;
      end else begin
         a_n = a_i[15:0]; b_n = b_i[15:0]; s_n = s_i; m_n = m_i; cin_n = cin_i; in_valid_n = 1'b1;
      end
      n_tests++;
      if ((wide ? in_ready_w : in_ready_n) !== 1'b1) begin
         n_fail++;
         $display("FAIL run_op in_ready: got %b expected 1", wide ? in_ready_w : in_ready_n);
      end
      @(posedge clk); #1;
      in_valid_w = 1'b0;
      in_valid_n = 1'b0;
      lat = 1;
      while ((wide ? out_valid_w : out_valid_n) !== 1'b1 && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      f_o  = wide ? f_w : {16'd0, f_n};
      c_o  = wide ? c_w : c_n;
      eq_o = wide ? eq_w : eq_n;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      in_valid_n = 0; a_n = '0; b_n = '0; s_n = '0; m_n = 0; cin_n = 0; out_ready_n = 1;
      in_valid_w = 0; a_w = '0; b_w = '0; s_w = '0; m_w = 0; cin_w = 0; out_ready_w = 1;
      repeat (2) @(posedge clk);
      #1;
      n_tests++;
      if ({in_ready_n, out_valid_n, busy_n, eq_n, c_n} !== 5'b10000) begin
         n_fail++;
         $display("FAIL reset_flags_n: got %b expected 10000", {in_ready_n, out_valid_n, busy_n, eq_n, c_n});
      end
      n_tests++;
      if (f_n !== 16'h0000) begin n_fail++; $display("FAIL reset_f_n: got %h expected 0000", f_n); end
      n_tests++;
      if (st_n !== IDLE) begin n_fail++; $display("FAIL reset_state_n: got %0d expected %0d", st_n, IDLE); end
      n_tests++;
      if ({in_ready_w, out_valid_w, busy_w, eq_w, c_w} !== 5'b10000) begin
         n_fail++;
         $display("FAIL reset_flags_w: got %b expected 10000", {in_ready_w, out_valid_w, busy_w, eq_w, c_w});
      end
      n_tests++;
      if (f_w !== 32'h0) begin n_fail++; $display("FAIL reset_f_w: got %h expected 00000000", f_w); end
      n_tests++;
      if (st_w !== IDLE) begin n_fail++; $display("FAIL reset_state_w: got %0d expected %0d", st_w, IDLE); end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_directed();
      logic [31:0] f; logic c, eq; int lat;
      run_op(0, 32'h00FF, 32'h0001, S_ADD, 1'b0, 1'b0, f, c, eq, lat);
      n_tests++;
      if (f[15:0] !== 16'h0100) begin n_fail++; $display("FAIL add_f: got %h expected 0100", f[15:0]); end
      n_tests++;
      if ({c, eq} !== 2'b00) begin n_fail++; $display("FAIL add_c_eq: got %b expected 00", {c, eq}); end
      n_tests++;
      if (lat != 5) begin n_fail++; $display("FAIL add_latency: got %0d expected 5", lat); end

      run_op(0, 32'hFFFF, 32'h0001, S_ADD, 1'b0, 1'b0, f, c, eq, lat);
      n_tests++;
      if ({c, f[15:0]} !== 17'h10000) begin
         n_fail++; $display("FAIL carry_chain: got c=%b f=%h expected c=1 f=0000", c, f[15:0]);
      end

      run_op(0, 32'h0000, 32'h0000, S_ADD, 1'b0, 1'b1, f, c, eq, lat);
      n_tests++;
      if ({c, f[15:0]} !== 17'h00001) begin
         n_fail++; $display("FAIL carry_in: got c=%b f=%h expected c=0 f=0001", c, f[15:0]);
      end

      run_op(0, 32'h8000, 32'h0003, S_DEC, 1'b0, 1'b0, f, c, eq, lat);
      n_tests++;
      if (f[15:0] !== 16'h7FFF) begin n_fail++; $display("FAIL dec_f: got %h expected 7fff", f[15:0]); end

      run_op(0, 32'hA5A5, 32'hA5A5, 4'($urandom_range(0, 15)), 1'b1, 1'b0, f, c, eq, lat);
      n_tests++;
      if (eq !== 1'b1) begin n_fail++; $display("FAIL eq_logic: got %b expected 1", eq); end
      run_op(0, 32'hA5A5, 32'hA5A5, S_SUB, 1'b0, 1'b1, f, c, eq, lat);
      n_tests++;
      if ({eq, f[15:0]} !== 17'h10000) begin
         n_fail++; $display("FAIL eq_sub: got eq=%b f=%h expected eq=1 f=0000", eq, f[15:0]);
      end
      run_op(0, 32'hA5A5, 32'hA5A4, S_ADD, 1'b0, 1'b0, f, c, eq, lat);
      n_tests++;
      if ({eq, c, f[15:0]} !== 18'h14B49) begin
         n_fail++; $display("FAIL neq_add: got eq=%b c=%b f=%h expected eq=0 c=1 f=4b49", eq, c, f[15:0]);
      end
   endtask

   task automatic test_backpressure();
      int cnt;
      out_ready_n = 1'b0;
      a_n = 16'h3C3C; b_n = 16'h0F0F; s_n = S_ADD; m_n = 1'b0; cin_n = 1'b1; in_valid_n = 1'b1;
      @(posedge clk); #1;
      in_valid_n = 1'b0;
      a_n = 16'h0000;  // post-acceptance change must not matter
      cnt = 0;
      while (out_valid_n !== 1'b1 && cnt < 50) begin @(posedge clk); #1; cnt++; end
      for (int i = 0; i < 6; i++) begin
         in_valid_n = (i == 1);
         if (i == 1) begin a_n = 16'hFFFF; b_n = 16'hFFFF; end
         n_tests++;
         if ({out_valid_n, in_ready_n, busy_n, c_n, f_n} !== {4'b1010, 16'h4B4C}) begin
            n_fail++;
            $display("FAIL hold_%0d: got v/r/busy/c=%b f=%h expected 1010 f=4b4c", i,
                     {out_valid_n, in_ready_n, busy_n, c_n}, f_n);
         end
         @(posedge clk); #1;
      end
      in_valid_n = 1'b0;
      out_ready_n = 1'b1;
      @(posedge clk); #1;
      n_tests++;
      if ({out_valid_n, in_ready_n, busy_n, f_n} !== {3'b010, 16'h4B4C}) begin
         n_fail++;
         $display("FAIL release: got v/r/busy=%b f=%h expected 010 f=4b4c", {out_valid_n, in_ready_n, busy_n}, f_n);
      end
      @(posedge clk); #1;
      n_tests++;
      if ({busy_n, out_valid_n} !== 2'b00) begin
         n_fail++; $display("FAIL ignored_pulse: got busy/v=%b expected 00", {busy_n, out_valid_n});
      end
   endtask

   task automatic test_reset_mid_run();
      logic [31:0] f; logic c, eq; int lat;
      a_n = 16'hFFFF; b_n = 16'hFFFF; s_n = S_ADD; m_n = 1'b0; cin_n = 1'b0; in_valid_n = 1'b1;
      @(posedge clk); #1;
      in_valid_n = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      #1;
      n_tests++;
      if ({out_valid_n, in_ready_n, busy_n, c_n, f_n} !== {4'b0100, 16'h0000}) begin
         n_fail++;
         $display("FAIL mid_reset: got v/r/busy/c=%b f=%h expected 0100 f=0000",
                  {out_valid_n, in_ready_n, busy_n, c_n}, f_n);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      run_op(0, 32'h1234, 32'h1111, S_ADD, 1'b0, 1'b0, f, c, eq, lat);
      n_tests++;
      if ({c, f[15:0]} !== 17'h02345) begin
         n_fail++; $display("FAIL after_reset_op: got c=%b f=%h expected c=0 f=2345", c, f[15:0]);
      end
   endtask

   task automatic test_random_functions();
      logic [31:0] f, ra, rb; logic c, eq, rm, rc; logic [3:0] rs; logic [32:0] exp; int lat;
      for (int i = 0; i < 24; i++) begin
         ra = {16'd0, 16'($urandom)};
         rb = ($urandom_range(0, 3) == 0) ? ra : {16'd0, 16'($urandom)};
         rs = 4'($urandom_range(0, 15));
         rm = 1'($urandom_range(0, 1));
         rc = 1'($urandom_range(0, 1));
         exp = ref_alu(ra, rb, rs, rm, rc, 16);
         run_op(0, ra, rb, rs, rm, rc, f, c, eq, lat);
         n_tests++;
         if (f[15:0] !== exp[15:0] || eq !== (ra == rb) || (!rm && c !== exp[32])) begin
            n_fail++;
            $display("FAIL rand_fn s=%h m=%b a=%h b=%h: got f=%h c=%b eq=%b expected f=%h c=%b eq=%b",
                     rs, rm, ra[15:0], rb[15:0], f[15:0], c, eq, exp[15:0], exp[32], ra == rb);
         end
      end
   endtask

   task automatic test_width32();
      logic [31:0] f; logic c, eq; int lat;
      run_op(1, 32'h0000FFFF, 32'h00000001, S_ADD, 1'b0, 1'b0, f, c, eq, lat);
      n_tests++;
      if ({c, f} !== 33'h0_0001_0000) begin
         n_fail++; $display("FAIL w32_add: got c=%b f=%h expected c=0 f=00010000", c, f);
      end
      n_tests++;
      if (lat != 9) begin n_fail++; $display("FAIL w32_latency: got %0d expected 9", lat); end
   endtask

   task automatic test_back_to_back();
      fork
         begin : driver
            logic [31:0] ra, rb; logic rc; logic [32:0] e; int wait_cnt;
            for (int i = 0; i < 32; i++) begin
               ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1));
               a_w = ra; b_w = rb; cin_w = rc; s_w = S_ADD; m_w = 1'b0; in_valid_w = 1'b1;
               wait_cnt = 0;
               while (in_ready_w !== 1'b1 && wait_cnt < 100) begin @(posedge clk); #1; wait_cnt++; end
               e = ref_alu(ra, rb, S_ADD, 1'b0, rc, 32);
               exp_q.push_back({ra == rb, e});
               @(posedge clk); #1;
            end
            in_valid_w = 1'b0;
         end
         begin : monitor
            logic [33:0] e; int got, cyc;
            got = 0; cyc = 0;
            while (got < 32 && cyc < 3000) begin
               @(posedge clk); #1;
               cyc++;
               out_ready_w = 1'($urandom_range(0, 1));
               if (out_valid_w === 1'b1 && out_ready_w) begin
                  got++;
                  n_tests++;
                  if (exp_q.size() == 0) begin
                     n_fail++; $display("FAIL b2b_unexpected: got f=%h expected no result", f_w);
                  end else begin
                     e = exp_q.pop_front();
                     if ({eq_w, c_w, f_w} !== e) begin
                        n_fail++;
                        $display("FAIL b2b_result: got eq=%b c=%b f=%h expected eq=%b c=%b f=%h",
                                 eq_w, c_w, f_w, e[33], e[32], e[31:0]);
                     end
                  end
               end
            end
            n_tests++;
            if (got != 32) begin n_fail++; $display("FAIL b2b_count: got %0d expected 32", got); end
            out_ready_w = 1'b1;
         end
      join
      @(posedge clk); #1;
      n_tests++;
      if (exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_leftover: got %0d expected 0", exp_q.size()); end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_backpressure();
      test_reset_mid_run();
      test_random_functions();
      test_width32();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
